// File: rtl/add3_slice_sched.sv
// add3_slice_sched
//   Sequencer and round-robin arbiter in front of a shared external 3-bit
//   add slice. Two requesters submit W-bit additions (W = 3*DIGITS). The
//   winner's operands are latched and fed to the slice one 3-bit digit per
//   cycle, LSB first, with the slice carry-out recirculated as the next
//   carry-in. The finished sum is offered on a valid/ready response port.
//
// Ports
//   clk, rst_n                     clock (rising edge), async active-low reset
//   req0_valid/ready/a/b/cin       requester 0 (ready is combinational grant)
//   req1_valid/ready/a/b/cin       requester 1
//   slice_a, slice_b, slice_cin    digit operands to the external slice
//   slice_s                        slice result {carry, sum[2:0]}
//   rsp_valid/ready                response handshake
//   rsp_sum, rsp_cout, rsp_id      result, final carry, owning requester
//   busy                           high whenever the block is not idle
module add3_slice_sched #(
  parameter  int DIGITS = 4,
  localparam int W      = 3 * DIGITS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_cin,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_cin,
  output logic [2:0]   slice_a,
  output logic [2:0]   slice_b,
  output logic         slice_cin,
  input  logic [3:0]   slice_s,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_cout,
  output logic         rsp_id,
  output logic         busy
);

  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic          prio;       // requester favoured on the next contention
  logic [KW-1:0] k;          // digit currently on the slice
  logic          carry;      // carry into digit k; final carry once DONE
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  sum_reg;
  logic          id_reg;

  logic          accept;
  logic          grant_id;
  logic [2:0]    dig_a;
  logic [2:0]    dig_b;
  logic [W-1:0]  sum_nxt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, arbitration and request handshakes. A ready is only ever
  // raised in IDLE, so an accept can never coincide with a response
  // handshake (which only happens in DONE).
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    grant_id   = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid && (!req1_valid || !prio)) begin
          req0_ready = 1'b1;
          accept     = 1'b1;
          grant_id   = 1'b0;
        end else if (req1_valid) begin
          req1_ready = 1'b1;
          accept     = 1'b1;
          grant_id   = 1'b1;
        end
        if (accept) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (k == K_LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Digit select for the slice and write-back of the slice sum into digit k
  always_comb begin
    dig_a   = '0;
    dig_b   = '0;
    sum_nxt = sum_reg;
    for (int d = 0; d < DIGITS; d++) begin
      if (k == KW'(d)) begin
        dig_a                = a_reg[3*d +: 3];
        dig_b                = b_reg[3*d +: 3];
        sum_nxt[3*d +: 3]    = slice_s[2:0];
      end
    end
  end

  // Operand capture and digit-serial accumulation. Everything is cleared by
  // reset so an interrupted transaction leaves nothing visible behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio    <= 1'b0;
      k       <= '0;
      carry   <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      id_reg  <= 1'b0;
    end else if (accept) begin
      a_reg  <= req0_ready ? req0_a   : req1_a;
      b_reg  <= req0_ready ? req0_b   : req1_b;
      carry  <= req0_ready ? req0_cin : req1_cin;
      k      <= '0;
      id_reg <= grant_id;
      // prio only moves on a grant: the loser of this round (or the idle
      // requester) is favoured next time both ask together.
      prio   <= ~grant_id;
    end else if (state == RUN) begin
      sum_reg <= sum_nxt;
      carry   <= slice_s[3];
      k       <= k + KW'(1);
    end
  end

  // The slice sees zeros except while a digit is actually being computed
  assign slice_a   = (state == RUN) ? dig_a : 3'd0;
  assign slice_b   = (state == RUN) ? dig_b : 3'd0;
  assign slice_cin = (state == RUN) ? carry : 1'b0;

  assign rsp_valid = (state == DONE);
  assign rsp_sum   = sum_reg;
  assign rsp_cout  = carry;
  assign rsp_id    = id_reg;
  assign busy      = (state != IDLE);

endmodule
